mult_hilo_ctrl: RTL and testbench

Sequencer sitting directly upstream of the 16x16 shift-add multiplier in the ALU. It accepts MULT/MULTU requests from ALU decode and latches the operands. For signed ops it converts them to magnitudes, then drives the multiplier start/operand lines and waits for its done. It applies the sign fix-up and writes the 32-bit product into the HI/LO registers, holding a stall line for the CPU pipeline meanwhile.

---
 rtl/mult_hilo_ctrl_pkg.sv | 16 +
 rtl/mult_hilo_ctrl_sign_mag.sv | 14 +
 rtl/mult_hilo_ctrl.sv | 141 ++++++++++++++
 tb/tb_mult_hilo_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO sequencers (multiplier now, divider later).
package mult_hilo_ctrl_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int TIMEOUT_DEF = 40;

  // Encoding is fixed so debug tools and the divider controller agree on it.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FIXUP = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

endpackage

// File: rtl/mult_hilo_ctrl_sign_mag.sv
// Conditional two's-complement negate: res = neg ? -val : val (mod 2^W).
// Used for operand magnitudes and for the product sign fix-up.
module mult_hilo_ctrl_sign_mag #(
  parameter int W = 16
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  // Most-negative value maps to itself, which is the correct magnitude.
  always_comb res = neg ? (W'(0) - val) : val;

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Sequencer in front of the shift-add multiplier: latches operands, issues
// the multiply, waits for done (with timeout), fixes the sign and writes HI/LO.
//
// Handshake with the multiplier: mul_start is a one-cycle pulse in ISSUE;
// the multiplier samples it at the edge ending ISSUE and drops mul_done at
// that same edge, so any mul_done seen in WAIT belongs to this operation.
// mul_a/mul_b stay constant from acceptance until the next request.
module mult_hilo_ctrl
  import mult_hilo_ctrl_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clockMul,
  input  logic               reset,
  input  logic               req,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               result_valid,
  output logic               fault
);

  localparam int             CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TO_VAL = CW'(TIMEOUT);

  state_t             state, state_next;
  logic               neg;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_inc;
  logic               timeout_hit;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fix;

  mult_hilo_ctrl_sign_mag #(.W(WIDTH)) u_mag_a (
    .val (op_a),
    .neg (is_signed & op_a[WIDTH-1]),
    .res (mag_a)
  );

  mult_hilo_ctrl_sign_mag #(.W(WIDTH)) u_mag_b (
    .val (op_b),
    .neg (is_signed & op_b[WIDTH-1]),
    .res (mag_b)
  );

  mult_hilo_ctrl_sign_mag #(.W(2*WIDTH)) u_fix (
    .val (prod),
    .neg (neg),
    .res (prod_fix)
  );

  // Timeout counter arithmetic for the WAIT state.
  always_comb begin
    cnt_inc     = cnt + CW'(1);
    timeout_hit = (cnt_inc == TO_VAL);
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (req) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (mul_done)         state_next = ST_FIXUP;
        else if (timeout_hit) state_next = ST_IDLE;
      end
      ST_FIXUP: state_next = ST_WRITE;
      ST_WRITE: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clockMul) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Registered datapath and outputs, advanced according to the current state.
  always_ff @(posedge clockMul) begin
    if (reset) begin
      mul_start    <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      busy         <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      result_valid <= 1'b0;
      fault        <= 1'b0;
      neg          <= 1'b0;
      prod         <= '0;
      cnt          <= '0;
    end else begin
      mul_start    <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            neg       <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            mul_a     <= mag_a;
            mul_b     <= mag_b;
            busy      <= 1'b1;
            mul_start <= 1'b1;
          end
        end
        ST_ISSUE: cnt <= '0;
        ST_WAIT: begin
          if (mul_done) begin
            prod <= mul_product;
          end else begin
            cnt <= cnt_inc;
            if (timeout_hit) begin
              fault <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        ST_FIXUP: prod <= prod_fix;
        ST_WRITE: begin
          hi           <= prod[2*WIDTH-1:WIDTH];
          lo           <= prod[WIDTH-1:0];
          result_valid <= 1'b1;
          busy         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Bench for mult_hilo_ctrl with a 16-cycle behavioural multiplier.
module tb_mult_hilo_ctrl;

  logic        clockMul = 1'b0;
  logic        reset;
  logic        req;
  logic        is_signed;
  logic [15:0] op_a, op_b;
  logic        mul_start;
  logic [15:0] mul_a, mul_b;
  logic        mul_done = 1'b0;
  logic [31:0] mul_product = 32'h0;
  logic        busy;
  logic [15:0] hi, lo;
  logic        result_valid;
  logic        fault;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  mult_hilo_ctrl dut (
    .clockMul     (clockMul),
    .reset        (reset),
    .req          (req),
    .is_signed    (is_signed),
    .op_a         (op_a),
    .op_b         (op_b),
    .mul_start    (mul_start),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_done     (mul_done),
    .mul_product  (mul_product),
    .busy         (busy),
    .hi           (hi),
    .lo           (lo),
    .result_valid (result_valid),
    .fault        (fault)
  );

  // Clock.
  always #5 clockMul = ~clockMul;

  // Multiplier model: samples start, drops done, raises done 16 cycles later.
  logic [31:0] m_a = 32'h0, m_b = 32'h0;
  int          m_cnt = 0;
  logic        m_hold = 1'b0;
  always @(posedge clockMul) begin
    if (mul_start) begin
      m_cnt    <= 15;
      mul_done <= 1'b0;
      m_a      <= {16'h0, mul_a};
      m_b      <= {16'h0, mul_b};
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !m_hold) begin
        mul_done    <= 1'b1;
        mul_product <= m_a * m_b;
      end
    end
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: full-precision product of the architectural operands.
  function automatic logic [31:0] ref_prod(input logic s, input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sb;
    if (s) begin
      sa = 32'(signed'(a));
      sb = 32'(signed'(b));
      return 32'(sa * sb);
    end
    return {16'h0, a} * {16'h0, b};
  endfunction

  function automatic logic [15:0] ref_mag(input logic s, input logic [15:0] a);
    if (s && a[15]) return 16'(17'h10000 - {1'b0, a});
    return a;
  endfunction

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called on a negedge with the DUT idle; returns on the negedge after busy drops.
  task automatic run_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ea, input logic [15:0] eb, input int inject_at,
                        output logic [31:0] got, output int bc, output int rv_cnt,
                        output logic ab_ok);
    req = 1'b1; is_signed = s; op_a = a; op_b = b;
    @(negedge clockMul);
    req = 1'b0; is_signed = 1'($urandom); op_a = 16'($urandom); op_b = 16'($urandom);
    bc = 0; rv_cnt = 0; ab_ok = 1'b1;
    while (busy === 1'b1 && bc < 200) begin
      bc++;
      if (mul_a !== ea || mul_b !== eb) ab_ok = 1'b0;
      if (result_valid === 1'b1) rv_cnt++;
      if (bc == inject_at) begin
        req = 1'b1; is_signed = ~s; op_a = ~a; op_b = b + 16'd7;
      end
      @(negedge clockMul);
      req = 1'b0;
    end
    if (result_valid === 1'b1) rv_cnt++;
    got = {hi, lo};
  endtask

  typedef struct {
    logic        s;
    logic [15:0] a, b, ea, eb, ehi, elo;
  } vec_t;

  vec_t        tbl[6];
  logic [31:0] got, last, exp;
  int          bc, rv_cnt, stray;
  logic        ab_ok;

  initial begin
    tbl[0] = '{1'b0, 16'h0003, 16'h0005, 16'h0003, 16'h0005, 16'h0000, 16'h000F};
    tbl[1] = '{1'b1, 16'hFFFE, 16'h0003, 16'h0002, 16'h0003, 16'hFFFF, 16'hFFFA};
    tbl[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001};
    tbl[3] = '{1'b1, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h4000, 16'h0000};
    tbl[4] = '{1'b1, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'hC000, 16'h8000};
    tbl[5] = '{1'b1, 16'h0000, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 16'h0000};

    // Reset.
    reset = 1'b1; req = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clockMul);
    check("reset_outputs", 96'({mul_start, mul_a, mul_b, busy, hi, lo, result_valid, fault}), 96'(0));
    reset = 1'b0;
    @(negedge clockMul);

    // Table, back-to-back: each req lands in the cycle result_valid is high.
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].ea, tbl[i].eb, 0, got, bc, rv_cnt, ab_ok);
      check($sformatf("tbl%0d_hilo", i), 96'(got), 96'({tbl[i].ehi, tbl[i].elo}));
      check($sformatf("tbl%0d_busy_cycles", i), 96'(bc), 96'(19));
      check($sformatf("tbl%0d_rv_pulses", i), 96'(rv_cnt), 96'(1));
      check($sformatf("tbl%0d_operands_held", i), 96'(ab_ok), 96'(1));
    end
    last = {tbl[5].ehi, tbl[5].elo};
    @(negedge clockMul);
    check("rv_one_cycle", 96'(result_valid), 96'(0));

    // Request during WAIT is ignored.
    run_op(1'b1, 16'hFFF9, 16'h0123, 16'h0007, 16'h0123, 6, got, bc, rv_cnt, ab_ok);
    check("inject_hilo", 96'(got), 96'(ref_prod(1'b1, 16'hFFF9, 16'h0123)));
    check("inject_busy_cycles", 96'(bc), 96'(19));
    check("inject_operands_held", 96'(ab_ok), 96'(1));
    last = got;

    // HI/LO hold across idle cycles.
    repeat (10) @(negedge clockMul);
    check("idle_hold_hilo", 96'({hi, lo}), 96'(last));

    // Reset in the 8th WAIT cycle aborts; the late done is harmless.
    req = 1'b1; is_signed = 1'b0; op_a = 16'h0011; op_b = 16'h0022;
    @(negedge clockMul);
    req = 1'b0;
    repeat (8) @(negedge clockMul);
    reset = 1'b1;
    @(negedge clockMul);
    check("midop_reset_outputs", 96'({mul_start, mul_a, mul_b, busy, hi, lo, result_valid, fault}), 96'(0));
    reset = 1'b0;
    stray = 0;
    repeat (20) begin
      @(negedge clockMul);
      if (result_valid !== 1'b0 || busy !== 1'b0) stray++;
    end
    check("late_done_ignored", 96'(stray), 96'(0));

    // Normal operation resumes with a stale done level present.
    run_op(1'b0, 16'h1234, 16'h0010, 16'h1234, 16'h0010, 0, got, bc, rv_cnt, ab_ok);
    check("post_reset_hilo", 96'(got), 96'(32'h00012340));
    check("post_reset_busy_cycles", 96'(bc), 96'(19));
    last = got;

    // Multiplier never answers: timeout fault.
    m_hold = 1'b1;
    run_op(1'b0, 16'h0002, 16'h0002, 16'h0002, 16'h0002, 0, got, bc, rv_cnt, ab_ok);
    check("timeout_busy_cycles", 96'(bc), 96'(41));
    check("timeout_fault", 96'(fault), 96'(1));
    check("timeout_hilo_kept", 96'(got), 96'(last));
    check("timeout_no_rv", 96'(rv_cnt), 96'(0));
    m_hold = 1'b0;
    repeat (5) @(negedge clockMul);
    check("fault_sticky", 96'(fault), 96'(1));
    run_op(1'b0, 16'h0009, 16'h0009, 16'h0009, 16'h0009, 0, got, bc, rv_cnt, ab_ok);
    check("fault_sticky_after_op", 96'(fault), 96'(1));
    check("after_fault_hilo", 96'(got), 96'(32'h00000051));
    reset = 1'b1;
    @(negedge clockMul);
    reset = 1'b0;
    check("fault_cleared_by_reset", 96'(fault), 96'(0));
    @(negedge clockMul);

    // Randomised operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      logic        s;
      logic [15:0] a, b;
      logic [15:0] corners[5];
      corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
      s = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
      exp_q.push_back(ref_prod(s, a, b));
      run_op(s, a, b, ref_mag(s, a), ref_mag(s, b),
             ($urandom_range(0, 2) == 0) ? $urandom_range(2, 18) : 0,
             got, bc, rv_cnt, ab_ok);
      exp = exp_q.pop_front();
      check($sformatf("rand%0d_hilo", i), 96'(got), 96'(exp));
      check($sformatf("rand%0d_busy_cycles", i), 96'(bc), 96'(19));
      check($sformatf("rand%0d_operands", i), 96'(ab_ok), 96'(1));
      repeat ($urandom_range(0, 3)) @(negedge clockMul);
      check($sformatf("rand%0d_hold", i), 96'({hi, lo}), 96'(exp));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
